week_tracker: RTL and testbench
===============================

# week_tracker

Downstream consumer of the 0–6 counter. It samples the counter's `C`, `B`, `A` outputs on the shared clock and checks that every step is a legal increment with 6→0 wrap. It counts completed weeks (6→0 wraps), drives a seven-segment digit for the current value, and reports lock/error status. It is the display and supervision stage that sits directly after the counter in the lab design.

## Interface
Parameters:
- `WEEK_W`, default 8: width of the week counter.
- `RESYNC_N`, default 3: number of consecutive legal steps required to (re)acquire lock; legal range 1–7.

Ports:
- `CLK`  in  1: rising-edge clock, the same clock that drives the counter.
- `RST_N`  in  1: reset, asynchronous and active-low. The design uses one clock; reset is asynchronous, active-low.
- `C`  in  1: counter MSB.
- `B`  in  1: counter middle bit.
- `A`  in  1: counter LSB. Value `v = {C,B,A}`.
- `CLR_ERR`  in  1: synchronous clear of `ERR`.
- `SEG`  out  7: active-high segments, bit order `{g,f,e,d,c,b,a}`.
- `WEEK`  out  `WEEK_W`: count of 6→0 wraps observed while locked.
- `WEEK_TICK`  out  1: one-cycle pulse on the cycle `WEEK` increments.
- `LOCK`  out  1: high in state TRACK.
- `ERR`  out  1: sticky fault flag.

## Operation
- Two sample registers: `s1 <= v` on every edge, `s2 <= s1` on every edge.
- Legal step: `s1 == (s2==6 ? 0 : s2+1)`, with both samples ≤ 6.
- Illegal value: `s1 == 7`.
- FSM states: EMPTY → PRIMED → ACQ ↔ TRACK.
  - EMPTY: entered on reset. After one edge (`s1` loaded), go to PRIMED.
  - PRIMED: after one edge (`s2` loaded), go to ACQ with `g=0`.
  - ACQ: a legal step increments `g`. When `g` would reach `RESYNC_N`, go to TRACK and clear `g`. An illegal step sets `g=0`. `s1==7` also sets `ERR`.
  - TRACK: a legal step stays in TRACK. An illegal step or `s1==7` goes to ACQ with `g=0` and sets `ERR`.
- Week count: on an edge in TRACK with a legal step where `s2==6` and `s1==0`:
  - `WEEK <= WEEK+1`, wrapping mod 2^`WEEK_W`.
  - `WEEK_TICK <= 1` for that cycle only.
  - Wraps seen in ACQ are not counted, including the step that completes acquisition.
- Display: in ACQ or TRACK, `SEG <= decode(s1)` every edge. In EMPTY and PRIMED, `SEG` is held blank.
  - Decode values: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x40 (dash).
- `ERR`: once set, stays set until cleared.
  - `CLR_ERR` high at an edge clears `ERR`.
  - If a set condition and `CLR_ERR` occur at the same edge, set wins.
- A held (repeated) value is an illegal step.

## Timing
- Reset values (`RST_N` low, asynchronous): `s1=s2=0`, state EMPTY, `g=0`, `SEG=0x00`, `WEEK=0`, `WEEK_TICK=0`, `LOCK=0`, `ERR=0`.
- Reset mid-operation: all of the above take effect immediately. Acquisition restarts from EMPTY after release.
- Latency: a value present before edge k is in `s1` after edge k. `SEG`, `WEEK`, `WEEK_TICK`, `LOCK` and `ERR` reflect that value's step check after edge k+1.
- First edge after reset release: EMPTY→PRIMED.
- Second edge: PRIMED→ACQ.
- Third edge: first step check and first `SEG` update.
- With `RESYNC_N=3` and a clean counter, `LOCK` rises after the 5th edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Clean run: reset, then counter running 0..6 at a 20 ns clock.
  - `LOCK` rises at the 5th edge and `ERR` stays 0.
  - `WEEK` increments by 1 per 7 cycles with a single-cycle `WEEK_TICK` each time.
  - `SEG` cycles 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D.
- Skip fault: drive 0,1,2,4 while locked.
  - At the check of 2→4: `LOCK` falls and `ERR` is set.
  - Three legal steps later `LOCK` is high again and `ERR` is still 1.
- Illegal 7: drive 7 in TRACK.
  - `SEG` shows 0x40, `ERR` is 1, `LOCK` is 0.
  - `WEEK` is unchanged until relock and the next 6→0 wrap.
- `CLR_ERR`:
  - Pulse with no fault: `ERR` goes 1→0 at that edge.
  - Pulse on the same edge as a new skip: `ERR` stays 1.
- Week wrap: with `WEEK_W=2`, run 4 full weeks in TRACK. `WEEK` goes 1, 2, 3, 0, and `WEEK_TICK` pulses 4 times.
- Reset mid-run: assert `RST_N` low between edges.
  - Immediately: `SEG=0x00`, `WEEK=0`, `LOCK=0`, `ERR=0`.
  - After release: relock timing matches the clean run (5th edge).

Source files
------------

// File: rtl/week_tracker.sv
// Supervises a 0-6 counter: checks each sampled step, counts completed weeks
// while locked, drives a seven-segment digit and reports lock/fault status.
module week_tracker #(
  parameter int WEEK_W   = 8,
  parameter int RESYNC_N = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              C,
  input  logic              B,
  input  logic              A,
  input  logic              CLR_ERR,
  output logic [6:0]        SEG,
  output logic [WEEK_W-1:0] WEEK,
  output logic              WEEK_TICK,
  output logic              LOCK,
  output logic              ERR
);

  typedef enum logic [1:0] {EMPTY, PRIMED, ACQ, TRACK} state_t;

  localparam logic [2:0]        RESYNC   = 3'(RESYNC_N);
  localparam logic [WEEK_W-1:0] WEEK_ONE = WEEK_W'(1);

  state_t     state;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] g;
  logic [2:0] v;
  logic [2:0] succ;
  logic       legal;
  logic       wrap;
  logic       err_set;

  function automatic logic [6:0] decode(input logic [2:0] d);
    case (d)
      3'd0:    decode = 7'h3F;
      3'd1:    decode = 7'h06;
      3'd2:    decode = 7'h5B;
      3'd3:    decode = 7'h4F;
      3'd4:    decode = 7'h66;
      3'd5:    decode = 7'h6D;
      3'd6:    decode = 7'h7D;
      default: decode = 7'h40;
    endcase
  endfunction

  assign v = {C, B, A};

  // A step is legal only between in-range samples; a repeated value never is.
  always_comb begin
    succ    = (s2 == 3'd6) ? 3'd0 : s2 + 3'd1;
    legal   = (s1 != 3'd7) && (s2 != 3'd7) && (s1 == succ);
    wrap    = legal && (s2 == 3'd6) && (s1 == 3'd0);
    err_set = ((state == ACQ) && (s1 == 3'd7)) || ((state == TRACK) && !legal);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1        <= 3'd0;
      s2        <= 3'd0;
      state     <= EMPTY;
      g         <= 3'd0;
      SEG       <= 7'h00;
      WEEK      <= '0;
      WEEK_TICK <= 1'b0;
      LOCK      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      s1        <= v;
      s2        <= s1;
      WEEK_TICK <= 1'b0;
      // A new fault outranks a clear arriving on the same edge.
      ERR       <= err_set | (ERR & ~CLR_ERR);
      case (state)
        EMPTY: begin
          SEG   <= 7'h00;
          state <= PRIMED;
        end
        PRIMED: begin
          SEG   <= 7'h00;
          g     <= 3'd0;
          state <= ACQ;
        end
        ACQ: begin
          SEG <= decode(s1);
          if (legal) begin
            if (g + 3'd1 == RESYNC) begin
              g     <= 3'd0;
              state <= TRACK;
              LOCK  <= 1'b1;
            end else begin
              g <= g + 3'd1;
            end
          end else begin
            g <= 3'd0;
          end
        end
        TRACK: begin
          SEG <= decode(s1);
          if (legal) begin
            if (wrap) begin
              WEEK      <= WEEK + WEEK_ONE;
              WEEK_TICK <= 1'b1;
            end
          end else begin
            g     <= 3'd0;
            state <= ACQ;
            LOCK  <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_week_tracker.sv
// Scoreboard bench for week_tracker: a reference model pushes the expected
// outputs for each edge as stimulus is driven; each test pops and compares.
module tb_week_tracker;

  logic       clk;
  logic       rst_n;
  logic       c, b, a;
  logic       clr_err;
  logic [6:0] seg,  seg2;
  logic [7:0] week;
  logic [1:0] week2;
  logic       week_tick, week_tick2;
  logic       lock, lock2;
  logic       err, err2;

  week_tracker #(.WEEK_W(8), .RESYNC_N(3)) dut (
    .CLK(clk), .RST_N(rst_n), .C(c), .B(b), .A(a), .CLR_ERR(clr_err),
    .SEG(seg), .WEEK(week), .WEEK_TICK(week_tick), .LOCK(lock), .ERR(err)
  );

  week_tracker #(.WEEK_W(2), .RESYNC_N(3)) dut2 (
    .CLK(clk), .RST_N(rst_n), .C(c), .B(b), .A(a), .CLR_ERR(clr_err),
    .SEG(seg2), .WEEK(week2), .WEEK_TICK(week_tick2), .LOCK(lock2), .ERR(err2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] week;
    logic       tick;
    logic       lock;
    logic       err;
    logic [6:0] seg2;
    logic [1:0] week2;
    logic       tick2;
    logic       lock2;
    logic       err2;
  } obs_t;

  obs_t       sb[$];
  int         n_compared;
  int         n_mismatched;
  int         cnt;

  logic [6:0] seg_tab [0:7];
  int         m_s1, m_s2, m_phase, m_g, m_week;
  bit         m_tick, m_err;
  logic [6:0] m_seg;

  function automatic int after(input int x);
    return (x + 1) % 7;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("seg=%h week=%0d tick=%b lock=%b err=%b / w2: seg=%h week=%0d tick=%b lock=%b err=%b",
                     o.seg, o.week, o.tick, o.lock, o.err, o.seg2, o.week2, o.tick2, o.lock2, o.err2);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{seg, week, week_tick, lock, err, seg2, week2, week_tick2, lock2, err2};
    return o;
  endfunction

  function automatic obs_t expected();
    obs_t o;
    o.seg   = m_seg;
    o.week  = 8'(m_week);
    o.tick  = m_tick;
    o.lock  = (m_phase == 3);
    o.err   = m_err;
    o.seg2  = m_seg;
    o.week2 = 2'(m_week % 4);
    o.tick2 = m_tick;
    o.lock2 = (m_phase == 3);
    o.err2  = m_err;
    return o;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_phase = 0; m_g = 0; m_week = 0;
    m_tick = 0; m_err = 0; m_seg = 7'h00;
  endtask

  // Phases: 0 empty, 1 primed, 2 acquiring, 3 tracking.
  task automatic model_edge(input int v, input bit clr);
    bit ok;
    bit fault;
    ok     = (m_s1 <= 6) && (m_s2 <= 6) && (m_s1 == (m_s2 + 1) % 7);
    fault  = 0;
    m_tick = 0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_g     = 0;
    end else begin
      m_seg = seg_tab[m_s1];
      if (m_phase == 2) begin
        if (ok) begin
          m_g = m_g + 1;
          if (m_g == 3) begin
            m_phase = 3;
            m_g     = 0;
          end
        end else begin
          m_g   = 0;
          fault = (m_s1 == 7);
        end
      end else if (ok) begin
        if (m_s2 == 6 && m_s1 == 0) begin
          m_week = (m_week + 1) % 256;
          m_tick = 1;
        end
      end else begin
        m_phase = 2;
        m_g     = 0;
        fault   = 1;
      end
    end
    if (fault) m_err = 1;
    else if (clr) m_err = 0;
    m_s2 = m_s1;
    m_s1 = v;
  endtask

  task automatic tick(input int v, input bit clr);
    logic [2:0] vv;
    vv = 3'(v);
    {c, b, a} = vv;
    clr_err   = clr;
    model_edge(v, clr);
    sb.push_back(expected());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp_v;
    rst_n = 1'b0; clr_err = 1'b0; {c, b, a} = 3'b000;
    #1;
    model_reset();
    sb.push_back(expected());
    exp_v = sb.pop_front();
    got   = observe();
    n_compared++;
    if (got !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL reset got %s required %s", fmt(got), fmt(exp_v));
    end
    @(posedge clk);
    @(posedge clk);
    #5 rst_n = 1'b1;
  endtask

  task automatic test_clean();
    obs_t got, exp_v;
    int   lock_edge;
    lock_edge = 0;
    cnt = 0;
    for (int e = 1; e <= 35; e++) begin
      tick(cnt, 1'b0);
      cnt   = after(cnt);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL clean edge=%0d got %s required %s", e, fmt(got), fmt(exp_v));
      end
      if (lock_edge == 0 && lock === 1'b1) lock_edge = e;
    end
    n_compared++;
    if (lock_edge !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL clean_lock_edge got %0d required 5", lock_edge);
    end
  endtask

  task automatic test_skip();
    obs_t got, exp_v;
    int   seq[$];
    while (cnt != 0) begin
      seq.push_back(cnt);
      cnt = after(cnt);
    end
    seq.push_back(0); seq.push_back(1); seq.push_back(2);
    cnt = 4;
    repeat (12) begin
      seq.push_back(cnt);
      cnt = after(cnt);
    end
    foreach (seq[i]) begin
      tick(seq[i], 1'b0);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL skip step=%0d got %s required %s", i, fmt(got), fmt(exp_v));
      end
    end
  endtask

  task automatic test_illegal7();
    obs_t got, exp_v;
    int   seq[$];
    while (cnt != 3) begin
      seq.push_back(cnt);
      cnt = after(cnt);
    end
    seq.push_back(3);
    seq.push_back(7);
    cnt = 5;
    repeat (25) begin
      seq.push_back(cnt);
      cnt = after(cnt);
    end
    foreach (seq[i]) begin
      tick(seq[i], 1'b0);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL illegal7 step=%0d got %s required %s", i, fmt(got), fmt(exp_v));
      end
    end
  endtask

  task automatic test_clr_err();
    obs_t got, exp_v;
    int   seq[$];
    bit   clr[$];
    seq.push_back(cnt); clr.push_back(1'b1);
    cnt = after(cnt);
    while (cnt != 0) begin
      seq.push_back(cnt); clr.push_back(1'b0);
      cnt = after(cnt);
    end
    seq.push_back(0); clr.push_back(1'b0);
    seq.push_back(1); clr.push_back(1'b0);
    seq.push_back(2); clr.push_back(1'b0);
    seq.push_back(4); clr.push_back(1'b0);
    seq.push_back(5); clr.push_back(1'b1);
    cnt = 6;
    repeat (12) begin
      seq.push_back(cnt); clr.push_back(1'b0);
      cnt = after(cnt);
    end
    foreach (seq[i]) begin
      tick(seq[i], clr[i]);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL clr_err step=%0d got %s required %s", i, fmt(got), fmt(exp_v));
      end
    end
  endtask

  task automatic test_week_wrap();
    obs_t       got, exp_v;
    int         ticks2;
    logic [1:0] start2;
    ticks2 = 0;
    start2 = week2;
    for (int e = 0; e < 28; e++) begin
      tick(cnt, 1'b0);
      cnt   = after(cnt);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL week_wrap edge=%0d got %s required %s", e, fmt(got), fmt(exp_v));
      end
      if (week_tick2 === 1'b1) ticks2++;
    end
    n_compared++;
    if (ticks2 !== 4) begin
      n_mismatched++;
      $display("[TB] FAIL week_wrap_ticks got %0d required 4", ticks2);
    end
    n_compared++;
    if (week2 !== start2) begin
      n_mismatched++;
      $display("[TB] FAIL week_wrap_mod4 got %0d required %0d", week2, start2);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t got, exp_v;
    int   lock_edge;
    #4 rst_n = 1'b0;
    #1;
    model_reset();
    sb.push_back(expected());
    exp_v = sb.pop_front();
    got   = observe();
    n_compared++;
    if (got !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid got %s required %s", fmt(got), fmt(exp_v));
    end
    @(posedge clk);
    #5 rst_n = 1'b1;
    lock_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(cnt, 1'b0);
      cnt   = after(cnt);
      exp_v = sb.pop_front();
      got   = observe();
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL reset_relock edge=%0d got %s required %s", e, fmt(got), fmt(exp_v));
      end
      if (lock_edge == 0 && lock === 1'b1) lock_edge = e;
    end
    n_compared++;
    if (lock_edge !== 5) begin
      n_mismatched++;
      $display("[TB] FAIL reset_lock_edge got %0d required 5", lock_edge);
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h40};
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_clean();
    test_skip();
    test_illegal7();
    test_clr_err();
    test_week_wrap();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
